// File: rtl/result_deskew_writer.sv
// Purpose: de-skews column-staggered systolic-array partial-sum rows and writes them to the result SRAM.
// Latency: psum_valid at edge k -> sram_we after edge k+MATRIX_SIZE; 1 row/cycle, no backpressure.
// Optional feature macro RESULT_RELU_EN: negative partial sums are written as zero.
module result_deskew_writer #(
    parameter int ADDRESSSIZE     = 10,
    parameter int MATRIX_SIZE     = 32,
    parameter int PARTIAL_SUM_BW  = 24,
    parameter int WORDSIZE_Result = MATRIX_SIZE*PARTIAL_SUM_BW
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [ADDRESSSIZE-1:0]     base_addr,
    input  logic [WORDSIZE_Result-1:0] psum_in,
    input  logic                       psum_valid,
    output logic                       sram_we,
    output logic [ADDRESSSIZE-1:0]     sram_addr,
    output logic [WORDSIZE_Result-1:0] sram_wdata,
    output logic                       busy,
    output logic                       end_
);

    localparam int CW = $clog2(MATRIX_SIZE+1);
    localparam logic [CW-1:0] ROWS = CW'(MATRIX_SIZE);
    localparam logic [CW-1:0] LAST = CW'(MATRIX_SIZE-1);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    state_t                                       state;
    logic [CW-1:0]                                acc_cnt;
    logic [CW-1:0]                                wr_cnt;
    logic [ADDRESSSIZE-1:0]                       base_q;
    logic [MATRIX_SIZE-1:0]                       vld_sr;
    logic [MATRIX_SIZE-1:0][PARTIAL_SUM_BW-1:0]   in_q;
    logic [MATRIX_SIZE-1:0][PARTIAL_SUM_BW-1:0]   aligned;
    logic [MATRIX_SIZE-1:0][PARTIAL_SUM_BW-1:0]   row;
    logic                                         accept;

    assign accept = (state == DRAIN) && psum_valid && (acc_cnt < ROWS);

    // Array outputs are registered at the boundary; this stage is part of the MATRIX_SIZE latency.
    always_ff @(posedge clk) begin
        in_q <= psum_in;
    end

    // Column c waits MATRIX_SIZE-1-c cycles so every column lines up with the last one.
    for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_col
        localparam int D = MATRIX_SIZE - 1 - c;
        if (D == 0) begin : g_pass
            assign aligned[c] = in_q[c];
        end else begin : g_dly
            logic [PARTIAL_SUM_BW-1:0] sh [D];
            always_ff @(posedge clk) begin
                sh[0] <= in_q[c];
                for (int i = 1; i < D; i++) sh[i] <= sh[i-1];
            end
            assign aligned[c] = sh[D-1];
        end
    end

    always_comb begin
        row = aligned;
`ifdef RESULT_RELU_EN
        for (int c = 0; c < MATRIX_SIZE; c++) begin
            if (aligned[c][PARTIAL_SUM_BW-1]) row[c] = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            acc_cnt    <= '0;
            wr_cnt     <= '0;
            base_q     <= '0;
            vld_sr     <= '0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            busy       <= 1'b0;
            end_       <= 1'b0;
        end else begin
            vld_sr  <= {vld_sr[MATRIX_SIZE-2:0], accept};
            sram_we <= vld_sr[MATRIX_SIZE-1];
            end_    <= 1'b0;
            if (vld_sr[MATRIX_SIZE-1]) begin
                sram_addr  <= base_q + ADDRESSSIZE'(wr_cnt);
                sram_wdata <= row;
                wr_cnt     <= wr_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= DRAIN;
                        busy    <= 1'b1;
                        base_q  <= base_addr;
                        acc_cnt <= '0;
                        wr_cnt  <= '0;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (acc_cnt == LAST) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (vld_sr[MATRIX_SIZE-1] && wr_cnt == LAST) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    end_  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_deskew_writer.sv
// Bench for result_deskew_writer: job table plus randomized jobs against a row-schedule reference model.
module tb_result_deskew_writer;

    localparam int AW = 10;
    localparam int M  = 32;
    localparam int BW = 24;
    localparam int W  = M*BW;

    logic          clk = 1'b0;
    logic          rstn, start, psum_valid;
    logic [AW-1:0] base_addr, sram_addr;
    logic [W-1:0]  psum_in, sram_wdata;
    logic          sram_we, busy, end_;

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    logic [AW-1:0] hold_addr = '0;
    logic [W-1:0]  hold_data = '0;

    result_deskew_writer #(
        .ADDRESSSIZE(AW), .MATRIX_SIZE(M), .PARTIAL_SUM_BW(BW), .WORDSIZE_Result(W)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .psum_in(psum_in), .psum_valid(psum_valid),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .busy(busy), .end_(end_)
    );

    localparam logic [95:0] LO_BASIC = 96'h000003_000002_000001_000000;
`ifdef RESULT_RELU_EN
    localparam logic [95:0] LO_RELU  = 96'h000000_000007_000000_000000;
`else
    localparam logic [95:0] LO_RELU  = 96'h800000_000007_000000_FFFFFB;
`endif

    typedef struct {
        int         base;
        int         mode;      // 0 random data, 1 r*M+c, 2 ReLU corner row first
        int         gap;       // 0 back-to-back rows, 1 random gaps
        int         early;     // extra valid in the start cycle
        int         npulse;
        int         mid;       // edge of a second start (0 = none)
        int         exp_nwr;
        int         exp_first;
        int         exp_last;
        int         exp_lat;
        bit         chk_lo;
        logic [95:0] exp_lo;
    } vec_t;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] expw(input logic [W-1:0] r);
        expw = r;
`ifdef RESULT_RELU_EN
        for (int c = 0; c < M; c++)
            if (r[c*BW+BW-1]) expw[c*BW +: BW] = '0;
`endif
    endfunction

    task automatic run_job(input int base, input int mode, input int gap, input int early,
                           input int npulse, input int mid, input int rst_rows,
                           output int n_wr, output int first_a, output int last_a,
                           output int lat, output logic [95:0] lo);
        int         vs [48];
        logic [W-1:0] rowd [48];
        int         acc_e [M];
        int         acc_p [M];
        int         exp_j [512];
        int         p0, na, last_w, tmax, rst_t;
        bit         we_e, done;
        p0 = 0;
        if (early != 0) begin
            vs[0] = 0;
            p0 = 1;
        end
        for (int p = p0; p < npulse; p++)
            vs[p] = (p == p0) ? 1 : vs[p-1] + 1 + ((gap != 0) ? int'($urandom_range(0, 2)) : 0);
        for (int p = 0; p < npulse; p++) begin
            for (int c = 0; c < M; c++)
                rowd[p][c*BW +: BW] = (mode == 1) ? BW'(p*M + c) : BW'($urandom);
            if (mode == 2 && p == p0) begin
                rowd[p][0*BW +: BW] = 24'hFFFFFB;
                rowd[p][1*BW +: BW] = 24'h000000;
                rowd[p][2*BW +: BW] = 24'h000007;
                rowd[p][3*BW +: BW] = 24'h800000;
            end
        end
        // Reference: the first M valids after the start edge are the job's rows, each written M edges later.
        na = 0;
        for (int p = 0; p < npulse; p++) begin
            if (vs[p] >= 1 && na < M) begin
                acc_e[na] = vs[p];
                acc_p[na] = p;
                na++;
            end
        end
        last_w = acc_e[M-1] + M;
        tmax   = last_w + 4;
        for (int t = 0; t < 512; t++) exp_j[t] = -1;
        for (int j = 0; j < M; j++) exp_j[acc_e[j] + M] = j;
        rst_t = (rst_rows > 0) ? acc_e[rst_rows-1] + 2 : -1;
        n_wr = 0; first_a = -1; last_a = -1; lat = -1; lo = '0; done = 0;
        for (int t = 0; t < tmax && !done; t++) begin
            @(negedge clk);
            if (t == rst_t) begin
                rstn = 1'b0;
                start = 1'b0;
                #1;
                chk("rst_ctl", W'({sram_we, busy, end_, sram_addr}), '0);
                chk("rst_wdata", sram_wdata, '0);
                hold_addr = '0;
                hold_data = '0;
                @(negedge clk);
                rstn = 1'b1;
                for (int i = 0; i < 2*M + 4; i++) begin
                    @(negedge clk);
                    psum_valid = 1'($urandom);
                    psum_in    = {W/32{$urandom}};
                    @(posedge clk);
                    #1;
                    chk("post_rst_ctl", W'({sram_we, busy, end_, sram_addr}), '0);
                end
                done = 1;
            end else begin
                start      = (t == 0) || (t == mid);
                base_addr  = (t == 0) ? AW'(base) : AW'($urandom);
                psum_valid = 1'b0;
                for (int p = 0; p < npulse; p++)
                    if (vs[p] == t) psum_valid = 1'b1;
                for (int c = 0; c < M; c++) begin
                    psum_in[c*BW +: BW] = BW'($urandom);
                    for (int p = 0; p < npulse; p++)
                        if (vs[p] == t - c) psum_in[c*BW +: BW] = rowd[p][c*BW +: BW];
                end
                @(posedge clk);
                #1;
                we_e = (exp_j[t] >= 0);
                if (we_e) begin
                    hold_addr = AW'(base + exp_j[t]);
                    hold_data = expw(rowd[acc_p[exp_j[t]]]);
                end
                chk($sformatf("ctl@%0d", t), W'({sram_we, busy, end_, sram_addr}),
                    W'({we_e, t <= last_w, t == last_w + 1, hold_addr}));
                chk($sformatf("wdata@%0d", t), sram_wdata, hold_data);
                if (sram_we) begin
                    if (n_wr == 0) begin
                        first_a = int'(sram_addr);
                        lat     = t - acc_e[0];
                        lo      = sram_wdata[95:0];
                    end
                    last_a = int'(sram_addr);
                    n_wr++;
                end
            end
        end
        start      = 1'b0;
        psum_valid = 1'b0;
    endtask

    initial begin
        vec_t tbl [4];
        int   nwr, fa, la, lat, b;
        logic [95:0] lo;
        tbl[0] = '{0,    1, 0, 0, 32, 0,  32, 0,    31,  32, 1'b1, LO_BASIC};
        tbl[1] = '{100,  0, 0, 0, 32, 0,  32, 100,  131, 32, 1'b0, 96'h0};
        tbl[2] = '{1020, 0, 1, 1, 36, 12, 32, 1020, 27,  32, 1'b0, 96'h0};
        tbl[3] = '{500,  2, 1, 0, 34, 20, 32, 500,  531, 32, 1'b1, LO_RELU};

        rstn = 1'b0; start = 1'b0; psum_valid = 1'b0; psum_in = '0; base_addr = '0;
        #12;
        chk("reset_ctl", W'({sram_we, busy, end_, sram_addr}), '0);
        chk("reset_wdata", sram_wdata, '0);
        @(negedge clk);
        rstn = 1'b1;

        // Reset after three accepted rows, then a clean full job.
        run_job(0, 0, 0, 0, 32, 0, 3, nwr, fa, la, lat, lo);
        chk("rst_job_writes", W'(nwr), '0);
        run_job(200, 1, 0, 0, 32, 0, 0, nwr, fa, la, lat, lo);
        chk("clean_nwr", W'(nwr), W'(32));
        chk("clean_first", W'(fa), W'(200));
        chk("clean_last", W'(la), W'(231));

        for (int i = 0; i < 4; i++) begin
            run_job(tbl[i].base, tbl[i].mode, tbl[i].gap, tbl[i].early, tbl[i].npulse,
                    tbl[i].mid, 0, nwr, fa, la, lat, lo);
            chk($sformatf("tbl%0d_nwr", i),   W'(nwr), W'(tbl[i].exp_nwr));
            chk($sformatf("tbl%0d_first", i), W'(fa),  W'(tbl[i].exp_first));
            chk($sformatf("tbl%0d_last", i),  W'(la),  W'(tbl[i].exp_last));
            chk($sformatf("tbl%0d_lat", i),   W'(lat), W'(tbl[i].exp_lat));
            if (tbl[i].chk_lo) chk($sformatf("tbl%0d_lo", i), W'(lo), W'(tbl[i].exp_lo));
        end

        for (int i = 0; i < 3; i++) begin
            b = int'($urandom_range(0, 1023));
            run_job(b, 0, 1, int'($urandom_range(0, 1)), 32 + int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 40)), 0, nwr, fa, la, lat, lo);
            chk($sformatf("rnd%0d_nwr", i),  W'(nwr), W'(32));
            chk($sformatf("rnd%0d_last", i), W'(la),  W'((b + 31) % 1024));
            chk($sformatf("rnd%0d_lat", i),  W'(lat), W'(32));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
